// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// minDigits() sizes the BCD output for a given largest magnitude.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam int BCD_DIGIT_W     = 4;
  localparam int BCD_ADD3_THRESH = 5;

  // Smallest digit count d with 10^d > maxVal.
  function automatic int minDigits(input int maxVal);
    int d;
    int p;
    d = 1;
    p = 10;
    for (int i = 0; i < 8; i++) begin
      if (p <= maxVal) begin
        d = d + 1;
        p = p * 10;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Combinational double-dabble correction for one BCD digit:
// nibbles of 5 or more get 3 added before the next shift.
module bcd_add3
  import bin2bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_digit,
  output logic [BCD_DIGIT_W-1:0] o_digit
);

  always_comb begin
    o_digit = i_digit;
    if (i_digit >= BCD_DIGIT_W'(BCD_ADD3_THRESH)) begin
      o_digit = i_digit + BCD_DIGIT_W'(3);
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per clock, start/done handshake.
// Define BIN2BCD_SIGNED_EN to treat i_bin as two's complement and add the o_neg sign output.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_start,
  input  logic [WIDTH-1:0]              i_bin,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] o_bcd
`ifdef BIN2BCD_SIGNED_EN
  , output logic                        o_neg
`endif
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef BIN2BCD_SIGNED_EN
  localparam int MAX_MAG = 1 << (WIDTH - 1);
`else
  localparam int MAX_MAG = (1 << WIDTH) - 1;
`endif

  if (WIDTH < 4 || WIDTH > 16) begin : gWidthCheck
    $error("bin2bcd_seq: WIDTH must lie in 4..16");
  end
  if (DIGITS < minDigits(MAX_MAG)) begin : gDigitsCheck
    $error("bin2bcd_seq: DIGITS too small for the largest input magnitude");
  end

  state_t                 r_state;
  state_t                 w_stateNext;
  logic [WIDTH-1:0]       r_bin;
  logic [WIDTH-1:0]       w_capture;
  logic [BCD_W-1:0]       r_dig;
  logic [BCD_W-1:0]       w_adj;
  logic [BCD_W+WIDTH-1:0] w_shifted;
  logic [BCD_W-1:0]       r_bcd;
  logic [CNT_W-1:0]       r_count;
  logic                   w_lastShift;

`ifdef BIN2BCD_SIGNED_EN
  logic r_negPend;
  logic r_neg;

  // Negate at capture so the shift datapath only ever sees a magnitude.
  assign w_capture = i_bin[WIDTH-1] ? (~i_bin + WIDTH'(1)) : i_bin;
  assign o_neg     = r_neg;
`else
  assign w_capture = i_bin;
`endif

  for (genvar g = 0; g < DIGITS; g++) begin : gAdd3
    bcd_add3 u_add3 (
      .i_digit (r_dig[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .o_digit (w_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign w_shifted   = {w_adj, r_bin} << 1;
  assign w_lastShift = (r_count == CNT_W'(WIDTH - 1));
  assign o_bcd       = r_bcd;

  always_comb begin
    w_stateNext = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_stateNext = SHIFT;
        end
      end
      SHIFT: begin
        o_busy = 1'b1;
        if (w_lastShift) begin
          w_stateNext = DONE;
        end
      end
      DONE: begin
        o_done      = 1'b1;
        w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // r_bcd only moves on the final shift, so the displays never see partial digits.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_bin     <= '0;
      r_dig     <= '0;
      r_count   <= '0;
      r_bcd     <= '0;
`ifdef BIN2BCD_SIGNED_EN
      r_negPend <= 1'b0;
      r_neg     <= 1'b0;
`endif
    end else begin
      r_state <= w_stateNext;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_bin     <= w_capture;
            r_dig     <= '0;
            r_count   <= '0;
`ifdef BIN2BCD_SIGNED_EN
            r_negPend <= i_bin[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          r_bin   <= w_shifted[WIDTH-1:0];
          r_dig   <= w_shifted[BCD_W+WIDTH-1:WIDTH];
          r_count <= r_count + CNT_W'(1);
          if (w_lastShift) begin
            r_bcd <= w_shifted[BCD_W+WIDTH-1:WIDTH];
`ifdef BIN2BCD_SIGNED_EN
            r_neg <= r_negPend;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq (WIDTH=8, DIGITS=3) against a decimal-arithmetic model.
// Define BIN2BCD_SIGNED_EN to also exercise the signed build and o_neg.
module tb_bin2bcd_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  bin;
  logic        busy;
  logic        done;
  logic [11:0] bcd;
`ifdef BIN2BCD_SIGNED_EN
  logic        neg;
`endif

  int          vectors     = 0;
  int          miscompares = 0;
  logic [11:0] modelBcd    = '0;

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .i_start (start),
    .i_bin   (bin),
    .o_busy  (busy),
    .o_done  (done),
`ifdef BIN2BCD_SIGNED_EN
    .o_neg   (neg),
`endif
    .o_bcd   (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decimal digits of the operand's value (magnitude in the signed build).
  function automatic logic [11:0] refBcd(input logic [7:0] v);
    int          mag;
    logic [11:0] r;
    r = '0;
`ifdef BIN2BCD_SIGNED_EN
    mag = v[7] ? 256 - int'(v) : int'(v);
`else
    mag = int'(v);
`endif
    for (int i = 0; i < 3; i++) begin
      r[4*i +: 4] = 4'(mag % 10);
      mag = mag / 10;
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Watch a quiet stretch: no stray done pulse, bcd holds the last result.
  task automatic checkQuiet(input string tag, input int cycles);
    int extra;
    extra = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    checkOutput({tag, " extra done"}, extra, 0);
    checkOutput({tag, " bcd held"}, bcd, modelBcd);
  endtask

  // One conversion; optionally re-pulse start during SHIFT at cycle pulseAt.
  task automatic applyStimulus(input logic [7:0] v, input int pulseAt, input string tag);
    logic [11:0] exp;
    int          cyc;
    int          busyCnt;
    int          holdBad;
    exp     = refBcd(v);
    @(negedge clk);
    bin   = v;
    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    bin     = 8'($urandom);
    cyc     = 1;
    busyCnt = 0;
    holdBad = 0;
    while (done !== 1'b1 && cyc < 30) begin
      if (busy === 1'b1) busyCnt++;
      if (bcd !== modelBcd) holdBad++;
      start = (cyc == pulseAt) ? 1'b1 : 1'b0;
      bin   = 8'($urandom);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    checkOutput({tag, " done cycle"}, cyc, 9);
    checkOutput({tag, " busy cycles"}, busyCnt, 8);
    checkOutput({tag, " bcd hold during conversion"}, holdBad, 0);
    checkOutput({tag, " bcd"}, bcd, exp);
    checkOutput({tag, " busy in done"}, busy, 0);
`ifdef BIN2BCD_SIGNED_EN
    checkOutput({tag, " neg"}, neg, v[7]);
`endif
    modelBcd = exp;
    checkQuiet(tag, 12);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int dones;
    logic [11:0] exp47;

    reset = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset bcd", bcd, 0);
`ifdef BIN2BCD_SIGNED_EN
    checkOutput("reset neg", neg, 0);
`endif
    reset = 1'b0;

    applyStimulus(8'd0,   0, "zero");
    applyStimulus(8'd255, 0, "255");
    applyStimulus(8'd99,  0, "99");
    applyStimulus(8'd128, 3, "128 with ignored start");

    // Reset in the middle of a conversion of 200.
    @(negedge clk);
    bin   = 8'd200;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort busy", busy, 0);
    checkOutput("abort done", done, 0);
    checkOutput("abort bcd", bcd, 0);
    modelBcd = '0;
    checkQuiet("abort", 12);
    applyStimulus(8'd200, 0, "200 after abort");

    // start held high: back-to-back conversions every 10 cycles.
    exp47 = refBcd(8'd47);
    dones = 0;
    @(negedge clk);
    bin   = 8'd47;
    start = 1'b1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dones++;
        checkOutput("b2b done spacing", cyc, 9 + 10 * (dones - 1));
        checkOutput("b2b bcd", bcd, exp47);
      end
    end
    start = 1'b0;
    checkOutput("b2b done count", dones, 3);
    modelBcd = exp47;
    checkQuiet("b2b", 12);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(8'($urandom_range(0, 255)), 0, "random");
    end

`ifdef BIN2BCD_SIGNED_EN
    applyStimulus(8'h80, 0, "signed -128");
    applyStimulus(8'hFF, 0, "signed -1");
    applyStimulus(8'h7F, 0, "signed 127");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
